// File: rtl/m68k_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : m68k_bus_arbiter
// Purpose  : Takes the 68000 bus over BR/BG/BGACK and shares it round-robin
//            between the Pi transaction engine (req[0]) and a secondary engine.
// Revision : 1.0 - initial release
// ============================================================================
module m68k_bus_arbiter #(
    parameter int BG_TIMEOUT   = 255,
    parameter int IDLE_RELEASE = 0
) (
    input  logic       M68K_CLK,
    input  logic       _rst_in,
    input  logic       enable,
    input  logic [1:0] req,
    input  logic [1:0] done,
    input  logic       M68K_BG_n,
    input  logic       M68K_AS_n,
    input  logic       M68K_DTACK_n,
    input  logic       M68K_BGACK_n,
    output logic       br_oe,
    output logic       bgack_oe,
    output logic [1:0] gnt,
    output logic       bus_owned,
    output logic       timeout
);

    localparam logic [7:0] c_bg_timeout   = 8'(BG_TIMEOUT);
    localparam logic [7:0] c_idle_release = 8'(IDLE_RELEASE);
    localparam logic       c_keep_mode    = (IDLE_RELEASE == 0);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQUEST   = 3'd1,
        ST_WAIT_IDLE = 3'd2,
        ST_OWNED     = 3'd3,
        ST_GRANT     = 3'd4,
        ST_RELEASE   = 3'd5
    } state_t;

    state_t     state_q,     state_d;
    logic [3:0] meta_q,      meta_d;
    logic [3:0] sync_q,      sync_d;
    logic [7:0] bg_cnt_q,    bg_cnt_d;
    logic [7:0] idle_cnt_q,  idle_cnt_d;
    logic       rel_cnt_q,   rel_cnt_d;
    logic       arm_q,       arm_d;
    logic       last_q,      last_d;
    logic [1:0] gnt_q,       gnt_d;
    logic       br_oe_q,     br_oe_d;
    logic       bgack_oe_q,  bgack_oe_d;
    logic       bus_owned_q, bus_owned_d;
    logic       timeout_q,   timeout_d;

    logic       timeout_evt;
    logic       bg_s;
    logic       as_s;
    logic       dtack_s;
    logic       bgack_s;
    logic       bus_idle;
    logic       winner;
    logic [7:0] idle_inc;

    // Synchronised bus lines, all active-low.
    assign bg_s     = sync_q[0];
    assign as_s     = sync_q[1];
    assign dtack_s  = sync_q[2];
    assign bgack_s  = sync_q[3];
    assign bus_idle = as_s & dtack_s & bgack_s;

    // Lone requester wins; on contention the one not served last time wins.
    assign winner   = req[1] & (~req[0] | ~last_q);
    assign idle_inc = idle_cnt_q + 8'd1;

    always_comb begin
        meta_d      = {M68K_BGACK_n, M68K_DTACK_n, M68K_AS_n, M68K_BG_n};
        sync_d      = meta_q;
        state_d     = state_q;
        bg_cnt_d    = bg_cnt_q;
        rel_cnt_d   = rel_cnt_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        timeout_d   = timeout_q;
        timeout_evt = 1'b0;

        case (state_q)
            ST_IDLE: begin
                bg_cnt_d = 8'd0;
                if (enable && arm_q && (c_keep_mode || (req != 2'b00))) begin
                    state_d = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                if (!bg_s) begin
                    state_d = ST_WAIT_IDLE;
                end else if (bg_cnt_q == c_bg_timeout) begin
                    state_d     = ST_IDLE;
                    timeout_d   = 1'b1;
                    timeout_evt = 1'b1;
                end else if (!enable) begin
                    state_d = ST_IDLE;
                end else begin
                    bg_cnt_d = bg_cnt_q + 8'd1;
                end
            end
            ST_WAIT_IDLE: begin
                if (bus_idle) begin
                    state_d = ST_OWNED;
                end else if (!enable) begin
                    state_d = ST_IDLE;
                end
            end
            ST_OWNED: begin
                if (!enable) begin
                    state_d   = ST_RELEASE;
                    rel_cnt_d = 1'b0;
                end else if (req != 2'b00) begin
                    state_d = ST_GRANT;
                    gnt_d   = winner ? 2'b10 : 2'b01;
                    last_d  = winner;
                end else if (!c_keep_mode && (idle_inc == c_idle_release)) begin
                    state_d   = ST_RELEASE;
                    rel_cnt_d = 1'b0;
                end
            end
            ST_GRANT: begin
                // Only the owner's done ends the tenure; enable and req wait.
                if ((done & gnt_q) != 2'b00) begin
                    state_d = ST_OWNED;
                    gnt_d   = 2'b00;
                end
            end
            ST_RELEASE: begin
                if (rel_cnt_q) begin
                    state_d = ST_IDLE;
                end else begin
                    rel_cnt_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 2'b00;
            end
        endcase

        if ((req != 2'b00) || ((state_d == ST_OWNED) && (state_q != ST_OWNED))) begin
            idle_cnt_d = 8'd0;
        end else if (state_q == ST_OWNED) begin
            idle_cnt_d = idle_inc;
        end else begin
            idle_cnt_d = idle_cnt_q;
        end

        // A timeout disarms until enable is seen low at least once.
        if (!enable) begin
            arm_d = 1'b1;
        end else if (timeout_evt) begin
            arm_d = 1'b0;
        end else begin
            arm_d = arm_q;
        end

        br_oe_d     = (state_d == ST_REQUEST) || (state_d == ST_WAIT_IDLE);
        bgack_oe_d  = (state_d == ST_OWNED)   || (state_d == ST_GRANT);
        bus_owned_d = bgack_oe_d;
    end

    always_ff @(posedge M68K_CLK or posedge _rst_in) begin
        if (_rst_in) begin
            state_q     <= ST_IDLE;
            meta_q      <= 4'hF;
            sync_q      <= 4'hF;
            bg_cnt_q    <= 8'd0;
            idle_cnt_q  <= 8'd0;
            rel_cnt_q   <= 1'b0;
            arm_q       <= 1'b1;
            last_q      <= 1'b1;
            gnt_q       <= 2'b00;
            br_oe_q     <= 1'b0;
            bgack_oe_q  <= 1'b0;
            bus_owned_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            meta_q      <= meta_d;
            sync_q      <= sync_d;
            bg_cnt_q    <= bg_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            rel_cnt_q   <= rel_cnt_d;
            arm_q       <= arm_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            br_oe_q     <= br_oe_d;
            bgack_oe_q  <= bgack_oe_d;
            bus_owned_q <= bus_owned_d;
            timeout_q   <= timeout_d;
        end
    end

    assign br_oe     = br_oe_q;
    assign bgack_oe  = bgack_oe_q;
    assign gnt       = gnt_q;
    assign bus_owned = bus_owned_q;
    assign timeout   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_m68k_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_m68k_bus_arbiter
// Purpose  : Randomised self-checking bench; one keep-mode instance and one
//            idle-release instance share the stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_m68k_bus_arbiter;

    localparam int BG_TO    = 10;
    localparam int IDLE_REL = 4;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       enable  = 1'b0;
    logic [1:0] req     = 2'b00;
    logic [1:0] done    = 2'b00;
    logic       bg_n    = 1'b1;
    logic       as_n    = 1'b1;
    logic       dtack_n = 1'b1;
    logic       bgack_n = 1'b1;

    logic       br_k, bgack_k, own_k, to_k;
    logic [1:0] gnt_k;
    logic       br_r, bgack_r, own_r, to_r;
    logic [1:0] gnt_r;

    int cyc     = 0;
    int n_pass  = 0;
    int n_total = 0;
    int rr_last = 1;

    always #5 clk = ~clk;

    m68k_bus_arbiter #(.BG_TIMEOUT(BG_TO), .IDLE_RELEASE(0)) dut_k (
        .M68K_CLK     (clk),
        ._rst_in      (rst),
        .enable       (enable),
        .req          (req),
        .done         (done),
        .M68K_BG_n    (bg_n),
        .M68K_AS_n    (as_n),
        .M68K_DTACK_n (dtack_n),
        .M68K_BGACK_n (bgack_n),
        .br_oe        (br_k),
        .bgack_oe     (bgack_k),
        .gnt          (gnt_k),
        .bus_owned    (own_k),
        .timeout      (to_k)
    );

    m68k_bus_arbiter #(.BG_TIMEOUT(BG_TO), .IDLE_RELEASE(IDLE_REL)) dut_r (
        .M68K_CLK     (clk),
        ._rst_in      (rst),
        .enable       (enable),
        .req          (req),
        .done         (done),
        .M68K_BG_n    (bg_n),
        .M68K_AS_n    (as_n),
        .M68K_DTACK_n (dtack_n),
        .M68K_BGACK_n (bgack_n),
        .br_oe        (br_r),
        .bgack_oe     (bgack_r),
        .gnt          (gnt_r),
        .bus_owned    (own_r),
        .timeout      (to_r)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic reset_all();
        rst     = 1'b1;
        enable  = 1'b0;
        req     = 2'b00;
        done    = 2'b00;
        bg_n    = 1'b1;
        as_n    = 1'b1;
        dtack_n = 1'b1;
        bgack_n = 1'b1;
        tick();
        tick();
        rst     = 1'b0;
        rr_last = 1;
    endtask

    function automatic logic sel_br(input int sel);
        return (sel == 1) ? br_r : br_k;
    endfunction

    function automatic logic sel_bgack(input int sel);
        return (sel == 1) ? bgack_r : bgack_k;
    endfunction

    function automatic logic sel_own(input int sel);
        return (sel == 1) ? own_r : own_k;
    endfunction

    // BG_n falls after edge k; a busy line rises after edge j. A line change
    // reaches the controller three edges later, so ownership starts at k+4,
    // or j+3 when a busy line holds it off longer.
    task automatic acquire(input int sel, input int bg_delay, input int busy_len);
        int e, k, j, own, line;
        e    = cyc;
        k    = e + bg_delay;
        j    = k + busy_len;
        own  = (busy_len > 0) ? j + 3 : k + 4;
        line = $urandom_range(0, 2);
        enable = 1'b1;
        if (sel == 1) req = 2'b01;
        while (cyc < own) begin
            bg_n    = (cyc >= k) ? 1'b0 : 1'b1;
            as_n    = !((busy_len > 0) && (line == 0) && (cyc < j));
            dtack_n = !((busy_len > 0) && (line == 1) && (cyc < j));
            bgack_n = !((busy_len > 0) && (line == 2) && (cyc < j));
            tick();
            check("acq_br",    32'(sel_br(sel)),    32'((cyc >= e + 1) && (cyc < own)));
            check("acq_bgack", 32'(sel_bgack(sel)), 32'(cyc >= own));
            check("acq_owned", 32'(sel_own(sel)),   32'(cyc >= own));
        end
        as_n    = 1'b1;
        dtack_n = 1'b1;
        bgack_n = 1'b1;
    endtask

    // One tenure on the keep-mode instance, starting from OWNED.
    task automatic rr_round(input logic [1:0] r, input int hold);
        int         w;
        logic [1:0] g;
        if (r == 2'b01)      w = 0;
        else if (r == 2'b10) w = 1;
        else                 w = 1 - rr_last;
        g    = (w == 1) ? 2'b10 : 2'b01;
        req  = r;
        done = 2'b00;
        tick();
        check("rr_grant", 32'(gnt_k), 32'(g));
        rr_last = w;
        for (int h = 0; h < hold; h++) begin
            req  = 2'($urandom_range(0, 3));
            done = ($urandom_range(0, 1) == 1) ? ~g : 2'b00;
            tick();
            check("rr_hold", 32'(gnt_k), 32'(g));
        end
        req  = 2'($urandom_range(0, 3));
        done = g;
        tick();
        check("rr_done", 32'({gnt_k, own_k, bgack_k}), 32'(4'b0011));
        done = 2'b00;
    endtask

    initial begin
        int n;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_k", 32'({br_k, bgack_k, gnt_k, own_k, to_k}), 32'd0);
        check("rst_r", 32'({br_r, bgack_r, gnt_r, own_r, to_r}), 32'd0);
        rst = 1'b0;
        tick();
        check("idle_k", 32'({br_k, bgack_k, gnt_k, own_k, to_k}), 32'd0);

        // Acquisition with random BG latency and bus activity, then round-robin
        for (int it = 0; it < 4; it++) begin
            reset_all();
            acquire(0, $urandom_range(0, 4),
                    ($urandom_range(0, 1) == 1) ? $urandom_range(1, 6) : 0);
            for (int r = 0; r < 8; r++) begin
                if (it == 0 && r < 4) rr_round(2'b11, 2);
                else rr_round(2'($urandom_range(1, 3)), $urandom_range(0, 3));
            end
        end

        // enable drops while requester 1 holds the bus
        reset_all();
        acquire(0, $urandom_range(0, 3), 0);
        req = 2'b10;
        tick();
        check("s5_grant", 32'(gnt_k), 32'(2'b10));
        enable = 1'b0;
        n = $urandom_range(1, 4);
        for (int h = 0; h < n; h++) begin
            req  = 2'($urandom_range(0, 3));
            done = (h == 0) ? 2'b01 : 2'b00;
            tick();
            check("s5_hold", 32'(gnt_k), 32'(2'b10));
        end
        req  = 2'b00;
        done = 2'b10;
        tick();
        check("s5_done", 32'({gnt_k, own_k, bgack_k}), 32'(4'b0011));
        done = 2'b00;
        tick();
        check("s5_release", 32'({br_k, bgack_k, own_k}), 32'd0);
        enable = 1'b1;
        tick();
        check("s5_rel2_br", 32'(br_k), 32'd0);
        tick();
        check("s5_idle_br", 32'(br_k), 32'd0);
        tick();
        check("s5_rereq_br", 32'(br_k), 32'd1);

        // Idle-release instance
        reset_all();
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s6_no_req", 32'(br_r), 32'd0);
        end
        acquire(1, $urandom_range(0, 3), $urandom_range(0, 4));
        tick();
        check("s6_grant", 32'(gnt_r), 32'(2'b01));
        done = 2'b01;
        req  = 2'b00;
        bg_n = 1'b1;
        tick();
        check("s6_done", 32'({gnt_r, bgack_r}), 32'(3'b001));
        done = 2'b00;
        for (int i = 1; i <= IDLE_REL; i++) begin
            tick();
            check("s6_idle_bgack", 32'(bgack_r), 32'(i < IDLE_REL));
        end
        n = $urandom_range(2, 4);
        for (int i = 0; i < n; i++) begin
            tick();
            check("s6_released", 32'({br_r, bgack_r, own_r}), 32'd0);
        end
        acquire(1, $urandom_range(0, 3), $urandom_range(0, 4));
        tick();
        check("s6_regrant", 32'(gnt_r), 32'(2'b01));

        // BG timeout, re-arm, then asynchronous reset during GRANT
        reset_all();
        enable = 1'b1;
        for (int i = 1; i <= BG_TO + 4; i++) begin
            tick();
            check("to_br",   32'(br_k), 32'(i <= BG_TO + 1));
            check("to_flag", 32'(to_k), 32'(i >= BG_TO + 2));
        end
        n = $urandom_range(2, 5);
        for (int i = 0; i < n; i++) begin
            tick();
            check("to_blocked", 32'({br_k, to_k}), 32'(2'b01));
        end
        enable = 1'b0;
        tick();
        check("to_low", 32'({br_k, to_k}), 32'(2'b01));
        acquire(0, 0, 0);
        check("to_sticky", 32'(to_k), 32'd1);
        req = 2'b01;
        tick();
        check("s7_grant", 32'(gnt_k), 32'(2'b01));
        #3;
        rst = 1'b1;
        #1;
        check("s7_async_rst_k", 32'({br_k, bgack_k, gnt_k, own_k, to_k}), 32'd0);
        check("s7_async_rst_r", 32'({br_r, bgack_r, gnt_r, own_r, to_r}), 32'd0);
        tick();
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got %0d/%0d checks", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
